tmr_mac_neuron: RTL
===================

Name: tmr_mac_neuron

Overview:
- Parametrised successor of the single-shot TMR neuron.
- Accepts one input vector X and one CRC-protected weight vector Wcrc per transaction through a valid/ready handshake.
- Checks every weight's CRC and requests a refetch on error, with bounded retries.
- Computes the dot product serially, one input per cycle, in three redundant MAC lanes, majority-votes the result, then saturates it to fixed point.
- Sits between the weight memory/fetch unit and the next layer's input buffer.

Parameters:
- M, 8: number of inputs (channels) per neuron.
- N, 16: data/weight width, signed fixed point.
- CL, 8: CRC width appended to each weight.
- INTBITS, 6: integer bits of the Q format (INTBITS+FRACBITS==N).
- FRACBITS, 10: fraction bits.
- CRC_POLY, 8'h07: CRC generator polynomial, init 0, MSB-first, no reflection, no final XOR.
- MAX_RETRY, 2: refetch attempts before giving up.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  X/Wcrc valid.
- in_ready  out  1  block can accept X/Wcrc.
- X  in  M*N  inputs; channel i at [i*N +: N].
- Wcrc  in  M*(N+CL)  channel i word at [i*(N+CL) +: N+CL] = {w[N-1:0], crc[CL-1:0]}.
- out_valid  out  1  H/invalid valid.
- out_ready  in  1  downstream accepts result.
- H  out  N  voted, saturated neuron output, Q(INTBITS.FRACBITS).
- rfflag  out  1  one-cycle pulse: weight CRC error, refetch requested.
- invalid  out  1  qualified by out_valid: result unusable (retries exhausted).
- tmr_err  out  1  qualified by out_valid: at least one lane disagreed during the vote.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, H=0, rfflag=0, invalid=0, tmr_err=0, retry count=0, accumulators=0.
- FSM states: IDLE, CHECK, MAC, VOTE, OUT.
- IDLE: in_ready=1. On in_valid&&in_ready, register X and Wcrc, go to CHECK.
- CHECK (1 cycle): recompute the CRC of all M weights in parallel.
  - All match: clear the retry count, go to MAC.
  - Any mismatch with retry count < MAX_RETRY: pulse rfflag for this cycle, increment the count, return to IDLE. X stays latched, but a fresh X is re-accepted with the refetched weights.
  - Any mismatch with retry count == MAX_RETRY: go to OUT with invalid=1, H=0.
- MAC (M cycles, channel index k=0..M-1): each of three lanes does acc += X[k]*w[k].
  - Product is 2N-bit signed.
  - Accumulator ACCW = 2N+$clog2(M) bits signed, so no overflow is possible.
- VOTE (1 cycle):
  - Bitwise 2-of-3 majority of the three accumulators.
  - tmr_err=1 if any lane differs from the majority.
  - result = voted_acc >>> FRACBITS (arithmetic, truncation).
  - Saturate to [-2^(N-1), 2^(N-1)-1].
- OUT: out_valid=1 and H/invalid/tmr_err are held stable until out_ready. On out_valid&&out_ready, clear the retry count and go to IDLE.
- in_ready is 0 in CHECK, MAC, VOTE and OUT; no new transaction is accepted until the handshake completes.
- Latency: accept edge to out_valid = M+2 cycles when the CRC passes.
- out_ready already high at OUT entry: the result is consumed in one cycle; the next accept is one cycle later.
- in_valid high while not in IDLE: ignored, no side effects.
- rst_n asserted mid-operation: immediate return to reset values; a pending result is lost and the retry count is cleared.

Optional Feature:
- TMR_SCRUB_EN defined: every MAC cycle, all three lanes are overwritten with the bitwise majority of their next values, so a transient single-lane upset is corrected before it accumulates. tmr_err is sticky-set if any per-cycle mismatch occurred in the transaction.
- TMR_SCRUB_EN undefined: lanes run independently and are voted only in VOTE.

Decomposition:
- Package tmr_neuron_pkg:
  - state enum.
  - CRC step function (crc_next over one weight).
  - majority-of-3 function.
  - saturate function.
  - ACCW localparam formula.
- Sub-module tmr_mac_lane (N, ACCW): clear, enable, x, w, optional scrub-load input, acc output. It is instantiated three times.
- The CRC checker stays inline via the package function.

Test Plan:
- Basic dot product: X all 16'h0400 (1.0), all weights 16'h0400 with crc 8'h54 (Wcrc word 24'h040054). Required: out_valid exactly M+2=10 cycles after accept, H=16'h2000 (8.0), invalid=0, tmr_err=0.
- Negative result: weights all 16'hFC00 (-1.0) with the correct CRC. Required: H=16'hE000 (-8.0). Positive saturation: weights all 16'h6600 (25.5). Required: H=16'h7FFF.
- Refetch: channel 0 CRC corrupted by XOR 8'h01. Required: rfflag pulses one cycle, then in_ready returns. Resupply correct words. Required: H=16'h2000, invalid=0.
- Retries exhausted: corrupt CRC on 3 consecutive supplies. Required: two rfflag pulses, then out_valid with invalid=1, H=0.
- Lane fault: force one lane accumulator bit during MAC. Required: H is still correct. tmr_err=1 without scrub; with TMR_SCRUB_EN, same H and sticky tmr_err.
- Backpressure and reset: out_ready held low for 5 cycles. Required: H stable and in_ready=0 throughout. Then assert rst_n low mid-MAC. Required: out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/tmr_neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmr_neuron_pkg
// Description : Shared types and helper functions for the TMR MAC neuron:
//               state encoding, CRC over one weight, 2-of-3 majority,
//               fixed-point saturation and accumulator width formula.
// Revision    : 1.0 - initial release
// ============================================================================
package tmr_neuron_pkg;

    localparam int unsigned DATA_MAX_W = 64;
    localparam int unsigned CRC_MAX_W  = 32;
    localparam int unsigned ACC_MAX_W  = 128;

    typedef logic        [DATA_MAX_W-1:0] data_wide_t;
    typedef logic        [CRC_MAX_W-1:0]  crc_wide_t;
    typedef logic        [ACC_MAX_W-1:0]  acc_wide_t;
    typedef logic signed [ACC_MAX_W-1:0]  sacc_wide_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_MAC   = 3'd2,
        ST_VOTE  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Full-precision products summed over m channels cannot overflow this width.
    function automatic int acc_width(input int m, input int n);
        return 2 * n + $clog2(m);
    endfunction

    localparam int ACCW_DEFAULT = acc_width(8, 16);

    // MSB-first CRC, init 0, no reflection, no final XOR; only the low
    // nbits of data and low clw bits of the result are meaningful.
    function automatic crc_wide_t crc_next(input data_wide_t  data,
                                           input int unsigned nbits,
                                           input crc_wide_t   poly,
                                           input int unsigned clw);
        crc_wide_t crc;
        crc_wide_t mask;
        logic      fb;
        crc  = '0;
        mask = (crc_wide_t'(1) << clw) - crc_wide_t'(1);
        for (int i = DATA_MAX_W - 1; i >= 0; i--) begin
            if (i < int'(nbits)) begin
                fb  = crc[clw-1] ^ data[i];
                crc = (crc << 1) & mask;
                if (fb) begin
                    crc = crc ^ (poly & mask);
                end
            end
        end
        return crc;
    endfunction

    function automatic acc_wide_t maj3(input acc_wide_t a,
                                       input acc_wide_t b,
                                       input acc_wide_t c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Clamp a signed value to the n-bit two's complement range.
    function automatic data_wide_t sat(input sacc_wide_t v, input int unsigned n);
        sacc_wide_t hi;
        sacc_wide_t lo;
        hi = (sacc_wide_t'(1) <<< (n - 1)) - sacc_wide_t'(1);
        lo = -(sacc_wide_t'(1) <<< (n - 1));
        if (v > hi) begin
            return data_wide_t'(hi);
        end
        if (v < lo) begin
            return data_wide_t'(lo);
        end
        return data_wide_t'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : tmr_mac_lane
// Description : One redundant multiply-accumulate lane (acc += x*w, signed).
//               With TMR_SCRUB_EN defined the lane exposes its next value and
//               accepts a scrub load that overrides the accumulate.
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_mac_lane #(
    parameter int N    = 16,
    parameter int ACCW = 35
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
`ifdef TMR_SCRUB_EN
    input  logic            ld,
    input  logic [ACCW-1:0] ld_val,
    output logic [ACCW-1:0] acc_nxt,
`endif
    input  logic [N-1:0]    x,
    input  logic [N-1:0]    w,
    output logic [ACCW-1:0] acc
);

    logic signed [2*N-1:0] w_prod;
    logic [ACCW-1:0]       w_sum;
    logic [ACCW-1:0]       r_acc;

    assign w_prod = $signed(x) * $signed(w);
    assign w_sum  = r_acc + ACCW'(w_prod);
    assign acc    = r_acc;

`ifdef TMR_SCRUB_EN
    assign acc_nxt = w_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
`ifdef TMR_SCRUB_EN
        end else if (ld) begin
            r_acc <= ld_val;
`endif
        end else if (en) begin
            r_acc <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmr_mac_neuron.sv
`default_nettype none
// ============================================================================
// Module      : tmr_mac_neuron
// Description : CRC-checked weights, serial triple-redundant MAC, majority
//               vote and Q(INTBITS.FRACBITS) saturation. Optional per-cycle
//               lane scrubbing is enabled by defining TMR_SCRUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_mac_neuron
    import tmr_neuron_pkg::*;
#(
    parameter int            M         = 8,
    parameter int            N         = 16,
    parameter int            CL        = 8,
    parameter int            INTBITS   = 6,
    parameter int            FRACBITS  = 10,
    parameter logic [CL-1:0] CRC_POLY  = 8'h07,
    parameter int            MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [M*N-1:0]      X,
    input  logic [M*(N+CL)-1:0] Wcrc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        H,
    output logic                rfflag,
    output logic                invalid,
    output logic                tmr_err
);

    localparam int ACCW = acc_width(M, N);
    localparam int KW   = (M > 1) ? $clog2(M) : 1;
    localparam int RW   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    // Fraction shift; falls back to N-INTBITS if the format is inconsistent.
    localparam int c_shift = (INTBITS + FRACBITS == N) ? FRACBITS : N - INTBITS;
    localparam logic [KW-1:0] c_klast     = KW'(M - 1);
    localparam logic [RW-1:0] c_max_retry = RW'(MAX_RETRY);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [M*N-1:0]        r_x;
    logic [M*(N+CL)-1:0]   r_w;
    logic [RW-1:0]         r_retry;
    logic [KW-1:0]         r_k;
    logic [N-1:0]          r_h;
    logic                  r_invalid;
    logic                  r_tmr_err;

    logic [N-1:0]          w_xa [M];
    logic [N-1:0]          w_wa [M];
    logic [M-1:0]          w_crc_err;
    logic                  w_crc_bad;
    logic                  w_lane_clr;
    logic                  w_lane_en;
    logic [N-1:0]          w_xk;
    logic [N-1:0]          w_wk;
    logic [ACCW-1:0]       w_acc [3];
    logic [ACCW-1:0]       w_maj;
    logic                  w_vote_err;
    logic                  w_err_any;
    logic signed [ACCW-1:0] w_shift;
    logic [N-1:0]          w_sat;

    // Per-channel unpacking and parallel CRC recomputation.
    for (genvar i = 0; i < M; i++) begin : g_ch
        logic [N+CL-1:0] w_word;
        assign w_word       = r_w[i*(N+CL) +: (N+CL)];
        assign w_xa[i]      = r_x[i*N +: N];
        assign w_wa[i]      = w_word[N+CL-1:CL];
        assign w_crc_err[i] = (CL'(crc_next(data_wide_t'(w_wa[i]), N,
                                            crc_wide_t'(CRC_POLY), CL))
                               != w_word[CL-1:0]);
    end

    assign w_crc_bad = |w_crc_err;
    assign w_xk      = w_xa[r_k];
    assign w_wk      = w_wa[r_k];

`ifdef TMR_SCRUB_EN
    logic [ACCW-1:0] w_nxt [3];
    logic [ACCW-1:0] w_nxt_maj;
    logic            w_scrub_err;
    logic            r_scrub_err;

    assign w_nxt_maj   = ACCW'(maj3(acc_wide_t'(w_nxt[0]), acc_wide_t'(w_nxt[1]),
                                    acc_wide_t'(w_nxt[2])));
    assign w_scrub_err = (w_nxt[0] != w_nxt_maj) | (w_nxt[1] != w_nxt_maj) |
                         (w_nxt[2] != w_nxt_maj);

    // Any corrected upset in the transaction must still be reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scrub_err <= 1'b0;
        end else if (w_lane_clr) begin
            r_scrub_err <= 1'b0;
        end else if (w_lane_en && w_scrub_err) begin
            r_scrub_err <= 1'b1;
        end
    end

    assign w_err_any = w_vote_err | r_scrub_err;
`else
    assign w_err_any = w_vote_err;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_lane
        tmr_mac_lane #(
            .N    (N),
            .ACCW (ACCW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (w_lane_clr),
            .en      (w_lane_en),
`ifdef TMR_SCRUB_EN
            .ld      (w_lane_en),
            .ld_val  (w_nxt_maj),
            .acc_nxt (w_nxt[g]),
`endif
            .x       (w_xk),
            .w       (w_wk),
            .acc     (w_acc[g])
        );
    end

    assign w_maj      = ACCW'(maj3(acc_wide_t'(w_acc[0]), acc_wide_t'(w_acc[1]),
                                   acc_wide_t'(w_acc[2])));
    assign w_vote_err = (w_acc[0] != w_maj) | (w_acc[1] != w_maj) |
                        (w_acc[2] != w_maj);
    assign w_shift    = $signed(w_maj) >>> c_shift;
    assign w_sat      = N'(sat(sacc_wide_t'(w_shift), N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        rfflag      = 1'b0;
        w_lane_clr  = 1'b0;
        w_lane_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_lane_clr = 1'b1;
                if (!w_crc_bad) begin
                    w_state_nxt = ST_MAC;
                end else if (r_retry < c_max_retry) begin
                    rfflag      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_MAC: begin
                w_lane_en = 1'b1;
                if (r_k == c_klast) begin
                    w_state_nxt = ST_VOTE;
                end
            end
            ST_VOTE: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_w       <= '0;
            r_retry   <= '0;
            r_k       <= '0;
            r_h       <= '0;
            r_invalid <= 1'b0;
            r_tmr_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x <= X;
                        r_w <= Wcrc;
                    end
                end
                ST_CHECK: begin
                    r_k <= '0;
                    if (!w_crc_bad) begin
                        r_retry <= '0;
                    end else if (r_retry < c_max_retry) begin
                        r_retry <= r_retry + 1'b1;
                    end else begin
                        r_h       <= '0;
                        r_invalid <= 1'b1;
                        r_tmr_err <= 1'b0;
                    end
                end
                ST_MAC: begin
                    r_k <= (r_k == c_klast) ? '0 : r_k + 1'b1;
                end
                ST_VOTE: begin
                    r_h       <= w_sat;
                    r_invalid <= 1'b0;
                    r_tmr_err <= w_err_any;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_retry <= '0;
                    end
                end
                default: begin
                    r_k <= '0;
                end
            endcase
        end
    end

    assign H       = r_h;
    assign invalid = r_invalid;
    assign tmr_err = r_tmr_err;

endmodule
`default_nettype wire
